// File: rtl/lock_pkg.sv
// Shared state encoding, default timing constants and helpers for the lock controller.
package lock_pkg;

  localparam int DEB_CYCLES_DEF  = 240000;
  localparam int OPEN_CYCLES_DEF = 60000000;
  localparam int LOCK_CYCLES_DEF = 120000000;
  localparam int MAX_TRY_DEF     = 3;

  localparam logic [2:0] ST_SETUP  = 3'd0;
  localparam logic [2:0] ST_LOCKED = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_OPEN   = 3'd3;
  localparam logic [2:0] ST_ALARM  = 3'd4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes a raw active-low key, debounces it and emits one pulse per accepted press.
module key_debounce
  import lock_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int W = cnt_width(DEB_CYCLES);
  localparam logic [W-1:0] RELOAD = W'(DEB_CYCLES - 1);

  logic         sync1;
  logic         sync2;
  logic         level;
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= RELOAD;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample agreeing with the accepted level restarts the stability window.
      if (sync2 == level) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        level <= sync2;
        cnt   <= RELOAD;
        press <= ~sync2;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/lock_ctrl.sv
// Password lock sequencer: programs the password, checks entries, opens, and locks out after failures.
//   state  | meaning
//   SETUP  | waiting for the first password to be programmed
//   LOCKED | closed, waiting for an entry attempt
//   CHECK  | single cycle evaluating com_result
//   OPEN   | unlocked, hold timer running; set key reprograms
//   ALARM  | lockout after MAX_TRY failures, all keys ignored
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int OPEN_CYCLES = OPEN_CYCLES_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int MAX_TRY     = MAX_TRY_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_set_n,
  input  logic       key_enter_n,
  input  logic [7:0] sw,
  input  logic       com_result,
  output logic [7:0] ctrl,
  output logic       enter_trig,
  output logic       unlock,
  output logic       alarm,
  output logic [1:0] try_cnt
);

  localparam int TW = cnt_width(max2(OPEN_CYCLES, LOCK_CYCLES));
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [1:0]    TRY_MAX   = 2'(MAX_TRY);

  logic          set_p;
  logic          enter_p;
  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [1:0]    try_inc;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_set_n),
    .press (set_p)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_enter_n),
    .press (enter_p)
  );

  assign try_inc = (try_cnt == TRY_MAX) ? try_cnt : try_cnt + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_SETUP;
      ctrl       <= 8'h00;
      enter_trig <= 1'b0;
      unlock     <= 1'b0;
      alarm      <= 1'b0;
      try_cnt    <= 2'd0;
      timer      <= '0;
    end else begin
      enter_trig <= 1'b0;
      case (state)
        ST_SETUP: begin
          if (set_p) begin
            ctrl       <= sw;
            enter_trig <= 1'b1;
            state      <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (enter_p) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (com_result) begin
            try_cnt <= 2'd0;
            unlock  <= 1'b1;
            timer   <= OPEN_LOAD;
            state   <= ST_OPEN;
          end else begin
            try_cnt <= try_inc;
            if (try_inc == TRY_MAX) begin
              alarm <= 1'b1;
              timer <= LOCK_LOAD;
              state <= ST_ALARM;
            end else begin
              state <= ST_LOCKED;
            end
          end
        end
        ST_OPEN: begin
          // Reprogramming takes priority over an expiring hold timer.
          if (set_p) begin
            ctrl       <= sw;
            enter_trig <= 1'b1;
            unlock     <= 1'b0;
            timer      <= '0;
            state      <= ST_LOCKED;
          end else if (timer == '0) begin
            unlock <= 1'b0;
            state  <= ST_LOCKED;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_ALARM: begin
          if (timer == '0) begin
            alarm   <= 1'b0;
            try_cnt <= 2'd0;
            state   <= ST_LOCKED;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= ST_SETUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed self-checking bench for lock_ctrl with short debounce and hold timers.
module tb_lock_ctrl;
  import lock_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_set_n;
  logic       key_enter_n;
  logic [7:0] sw;
  logic       com_result;
  logic [7:0] ctrl;
  logic       enter_trig;
  logic       unlock;
  logic       alarm;
  logic [1:0] try_cnt;

  int checks = 0;
  int failures = 0;
  int trig_tot = 0;
  int unlock_tot = 0;
  int alarm_tot = 0;
  int trig_consec = 0;
  logic trig_q = 1'b0;

  lock_ctrl #(
    .DEB_CYCLES  (4),
    .OPEN_CYCLES (10),
    .LOCK_CYCLES (20),
    .MAX_TRY     (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_set_n   (key_set_n),
    .key_enter_n (key_enter_n),
    .sw          (sw),
    .com_result  (com_result),
    .ctrl        (ctrl),
    .enter_trig  (enter_trig),
    .unlock      (unlock),
    .alarm       (alarm),
    .try_cnt     (try_cnt)
  );

  always #5 clk = ~clk;

  // Running totals of high cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (enter_trig === 1'b1) trig_tot++;
    if (unlock === 1'b1) unlock_tot++;
    if (alarm === 1'b1) alarm_tot++;
    if (enter_trig === 1'b1 && trig_q === 1'b1) trig_consec++;
    trig_q = enter_trig;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input bit is_set, input int hold, input int settle);
    if (is_set) key_set_n = 1'b0;
    else        key_enter_n = 1'b0;
    tick(hold);
    key_set_n   = 1'b1;
    key_enter_n = 1'b1;
    tick(settle);
  endtask

  initial begin
    int t0;
    int u0;
    int a0;
    bit found;
    logic prev_unlock;

    rst_n       = 1'b0;
    key_set_n   = 1'b1;
    key_enter_n = 1'b1;
    sw          = 8'h00;
    com_result  = 1'b0;
    tick(3);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_trig", enter_trig, 0);
    chk("rst_unlock", unlock, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_try", try_cnt, 0);
    chk("rst_state", dut.state, ST_SETUP);
    rst_n = 1'b1;
    tick(2);

    // Bouncing set key, every low run shorter than the window.
    t0 = trig_tot;
    sw = 8'h77;
    key_set_n = 1'b0; tick(2);
    key_set_n = 1'b1; tick(2);
    key_set_n = 1'b0; tick(3);
    key_set_n = 1'b1; tick(3);
    key_set_n = 1'b0; tick(1);
    key_set_n = 1'b1; tick(10);
    chk("bounce_trig", trig_tot - t0, 0);
    chk("bounce_ctrl", ctrl, 0);
    chk("bounce_state", dut.state, ST_SETUP);

    // Program A5.
    sw = 8'hA5;
    t0 = trig_tot;
    press(1'b1, 10, 10);
    chk("prog_trig_cnt", trig_tot - t0, 1);
    chk("prog_ctrl", ctrl, 8'hA5);
    chk("prog_state", dut.state, ST_LOCKED);

    // Correct entry opens for exactly 10 cycles.
    com_result = 1'b1;
    u0 = unlock_tot;
    press(1'b0, 10, 30);
    chk("open_width", unlock_tot - u0, 10);
    chk("open_try", try_cnt, 0);
    chk("open_after_state", dut.state, ST_LOCKED);
    chk("open_after_unlock", unlock, 0);

    // Three failures lead to a 20-cycle alarm.
    com_result = 1'b0;
    press(1'b0, 8, 8);
    chk("fail1_try", try_cnt, 1);
    chk("fail1_state", dut.state, ST_LOCKED);
    press(1'b0, 8, 8);
    chk("fail2_try", try_cnt, 2);
    chk("fail2_alarm", alarm, 0);
    a0 = alarm_tot;
    press(1'b0, 8, 8);
    chk("fail3_alarm", alarm, 1);
    chk("fail3_try", try_cnt, 3);
    chk("fail3_state", dut.state, ST_ALARM);
    press(1'b0, 6, 6);
    tick(15);
    chk("alarm_width", alarm_tot - a0, 20);
    chk("alarm_after_try", try_cnt, 0);
    chk("alarm_after_state", dut.state, ST_LOCKED);
    chk("alarm_after_alarm", alarm, 0);

    // Reprogram while open.
    com_result = 1'b1;
    key_enter_n = 1'b0;
    tick(8);
    chk("reprog_open", unlock, 1);
    key_enter_n = 1'b1;
    sw = 8'h3C;
    key_set_n = 1'b0;
    t0 = trig_tot;
    found = 1'b0;
    prev_unlock = unlock;
    for (int i = 0; i < 20 && !found; i++) begin
      prev_unlock = unlock;
      tick(1);
      if (enter_trig === 1'b1) found = 1'b1;
    end
    chk("reprog_seen", found, 1);
    chk("reprog_unlock_drop", unlock, 0);
    chk("reprog_prev_unlock", prev_unlock, 1);
    chk("reprog_state", dut.state, ST_LOCKED);
    chk("reprog_ctrl", ctrl, 8'h3C);
    key_set_n = 1'b1;
    tick(10);
    chk("reprog_trig_cnt", trig_tot - t0, 1);
    chk("trig_never_consec", trig_consec, 0);

    // Reset in the middle of an alarm.
    com_result = 1'b0;
    press(1'b0, 8, 8);
    press(1'b0, 8, 8);
    press(1'b0, 8, 8);
    chk("rst_alarm_pre", alarm, 1);
    rst_n = 1'b0;
    tick(1);
    chk("rst_alarm_drop", alarm, 0);
    chk("rst_alarm_state", dut.state, ST_SETUP);
    chk("rst_alarm_try", try_cnt, 0);
    chk("rst_alarm_ctrl", ctrl, 0);
    rst_n = 1'b1;
    tick(2);

    // Enter is ignored before a password exists.
    press(1'b0, 8, 8);
    chk("setup_enter_ignored", dut.state, ST_SETUP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lock_ctrl.md
LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 240000, debounce stability window in clk cycles (20 ms at 12 MHz).
REQ-002 Parameter OPEN_CYCLES, default 60000000, unlock hold time in clk cycles.
REQ-003 Parameter LOCK_CYCLES, default 120000000, alarm lockout time in clk cycles.
REQ-004 Parameter MAX_TRY, default 3, failed attempts (1..3) that trigger alarm.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 key_set_n  input  1  raw "set password" button, active-low, asynchronous to clk.
REQ-008 key_enter_n  input  1  raw "enter/check" button, active-low, asynchronous to clk.
REQ-009 sw  input  8  switch bank; password value to program.
REQ-010 com_result  input  1  compare result: 1 when stored password equals live sw.
REQ-011 ctrl  output  8  password value to store; held stable between programming events.
REQ-012 enter_trig  output  1  one-cycle store strobe for ctrl.
REQ-013 unlock  output  1  lock open indicator.
REQ-014 alarm  output  1  lockout indicator.
REQ-015 try_cnt  output  2  current failed-attempt count.

Function
REQ-016 Each key SHALL pass a 2-FF synchronizer, then a debouncer accepting a new level only after DEB_CYCLES consecutive equal samples.
REQ-017 A debounced high-to-low transition SHALL yield exactly one single-cycle press pulse (set_p / enter_p); holding a key yields no further pulses.
REQ-018 FSM states: SETUP, LOCKED, CHECK, OPEN, ALARM; all outputs registered.
REQ-019 SETUP: on set_p, ctrl <= sw, enter_trig = 1 for the next cycle only, go to LOCKED; enter_p ignored.
REQ-020 LOCKED: on enter_p go to CHECK; set_p ignored.
REQ-021 CHECK (exactly one cycle): sample com_result; if 1, go to OPEN and clear try_cnt.
REQ-022 CHECK with com_result 0: increment try_cnt; if the new value equals MAX_TRY, go to ALARM, else LOCKED.
REQ-023 OPEN: unlock = 1; a timer counts OPEN_CYCLES, then unlock = 0, go to LOCKED.
REQ-024 OPEN with set_p: reprogram (ctrl <= sw, one-cycle enter_trig), go to LOCKED immediately, timer cleared.
REQ-025 ALARM: alarm = 1; all presses ignored; after LOCK_CYCLES, alarm = 0, try_cnt = 0, go to LOCKED.
REQ-026 Simultaneous set_p and enter_p: set_p wins in SETUP and OPEN; enter_p wins in LOCKED.
REQ-027 Timers SHALL be sized by $clog2 of the largest cycle parameter and SHALL NOT wrap; try_cnt SHALL saturate at MAX_TRY.
REQ-028 enter_trig SHALL never be asserted in two consecutive cycles and only in SETUP→LOCKED or OPEN→LOCKED transitions.

Reset
REQ-029 rst_n low at a clk edge: state SETUP, ctrl = 0, enter_trig = 0, unlock = 0, alarm = 0, try_cnt = 0, timers and debouncers cleared (debounced level = released).
REQ-030 Reset mid-OPEN or mid-ALARM SHALL abort the timer and drop unlock/alarm at the same edge.

Structure
REQ-031 FSM state encoding and default parameter constants SHALL reside in a shared package lock_pkg.
REQ-032 Debouncer plus edge detector SHALL be a sub-module key_debounce, instantiated once per key.

Verification
REQ-033 Use DEB_CYCLES=4, OPEN_CYCLES=10, LOCK_CYCLES=20, MAX_TRY=3 for all scenarios.
REQ-034 Scenario: reset, sw=8'hA5, key_set_n pressed 10 cycles -> one enter_trig pulse, ctrl=8'hA5, state LOCKED.
REQ-035 Scenario: key_set_n bouncing with pulses of fewer than 4 cycles -> no enter_trig pulse, ctrl stays 0.
REQ-036 Scenario: password A5, com_result=1, enter press -> unlock high for exactly 10 cycles, try_cnt=0.
REQ-037 Scenario: com_result=0, three enter presses -> try_cnt 1,2, then alarm high 20 cycles; a press during alarm is ignored; try_cnt=0 afterwards.
REQ-038 Scenario: in OPEN, sw=8'h3C, set press -> ctrl=8'h3C, one enter_trig pulse, unlock drops the same cycle state goes LOCKED.
REQ-039 Scenario: rst_n low during ALARM -> alarm=0 and state SETUP at the next edge.
